// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the quad_spi command arbiter: opcodes, FSM states,
// owner encoding and the opcode-to-command-pulse decode.
package qspi_arb_pkg;

  localparam logic [7:0] OP_CHIP_ID = 8'h04;
  localparam logic [7:0] OP_EN4B    = 8'h08;
  localparam logic [7:0] OP_PROG    = 8'h01;
  localparam logic [7:0] OP_SERASE  = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h20;

  localparam int CMD_READ    = 0;
  localparam int CMD_CHIP_ID = 1;
  localparam int CMD_EN4B    = 2;
  localparam int CMD_PROG    = 3;
  localparam int CMD_SERASE  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RISE,
    ST_WAIT_FALL,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    OWNER_HOST = 1'b0,
    OWNER_TAB  = 1'b1
  } owner_e;

  // One-hot command vector for an opcode; all-zero marks an unsupported opcode.
  function automatic logic [4:0] op_to_cmd(input logic [7:0] op);
    logic [4:0] cmd;
    cmd = '0;
    case (op)
      OP_READ:    cmd[CMD_READ]    = 1'b1;
      OP_CHIP_ID: cmd[CMD_CHIP_ID] = 1'b1;
      OP_EN4B:    cmd[CMD_EN4B]    = 1'b1;
      OP_PROG:    cmd[CMD_PROG]    = 1'b1;
      OP_SERASE:  cmd[CMD_SERASE]  = 1'b1;
      default:    cmd = '0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/qspi_de_window.sv
// Page-program data window: spi_flash_de rises the cycle after data_en and
// stays high for exactly DE_LEN cycles unless cleared earlier.
module qspi_de_window
  import qspi_arb_pkg::*;
#(
  parameter int DE_LEN = 514
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic data_en,
  input  logic clear,
  output logic de
);

  localparam logic [15:0] DE_LAST = 16'(DE_LEN - 1);

  logic        de_q, de_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    de_d  = de_q;
    cnt_d = cnt_q;
    if (clear || !arm) begin
      de_d  = 1'b0;
      cnt_d = '0;
    end else if (de_q) begin
      if (cnt_q == DE_LAST) de_d = 1'b0;
      else                  cnt_d = cnt_q + 16'd1;
    end else if (data_en) begin
      de_d  = 1'b1;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      de_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      de_q  <= de_d;
      cnt_q <= cnt_d;
    end
  end

  assign de = de_q;

endmodule

// File: rtl/qspi_cmd_arbiter.sv
// Shares quad_spi between the host command port and the NOR-table loader.
// Optional busy watchdog in WAIT_FALL: define QSPI_ARB_TIMEOUT_EN (adds TIMEOUT).
module qspi_cmd_arbiter
  import qspi_arb_pkg::*;
#(
`ifdef QSPI_ARB_TIMEOUT_EN
  parameter int TIMEOUT       = (1 << 24) - 1,
`endif
  parameter int DE_LEN        = 514,
  parameter int BUSY_WAIT     = 64,
  parameter int MAX_TAB_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic [7:0]  host_op,
  input  logic [23:0] host_addr,
  output logic        host_ack,
  output logic        host_done,
  output logic        host_err,
  input  logic        tab_req,
  input  logic [23:0] tab_addr,
  output logic        tab_ack,
  output logic        tab_done,
  output logic        spi_read_puls,
  output logic        spi_chip_id_read_puls,
  output logic        spi_enter_byte_4_addr_puls,
  output logic        spi_page_prgm_4_byte_puls,
  output logic        spi_erase_4_sector_puls,
  output logic [23:0] spi_address,
  output logic        spi_flash_de,
  input  logic        spi_data_en,
  input  logic        spi_flash_busy,
  input  logic        spi_rd_valid,
  output logic        owner,
  output logic        arb_busy,
  output logic [15:0] rd_byte_cnt
);

  localparam logic [7:0]  BURST_MAX = 8'(MAX_TAB_BURST);
  localparam logic [15:0] RISE_LAST = 16'(BUSY_WAIT - 1);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [7:0]  op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [7:0]  burst_q, burst_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [4:0]  cmd_q, cmd_d;
  logic        host_ack_q, host_ack_d, tab_ack_q, tab_ack_d;
  logic        host_done_q, host_done_d, host_err_q, host_err_d;
  logic        tab_done_q, tab_done_d;
  logic        de_arm;
`ifdef QSPI_ARB_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);
  logic [23:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    addr_d      = addr_q;
    err_d       = err_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    rd_cnt_d    = rd_cnt_q;
    cmd_d       = '0;
    host_ack_d  = 1'b0;
    tab_ack_d   = 1'b0;
    host_done_d = 1'b0;
    host_err_d  = 1'b0;
    tab_done_d  = 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        // Table wins unless the host has already waited out a full burst.
        if (tab_req && !(host_req && burst_q >= BURST_MAX)) begin
          state_d   = ST_ISSUE;
          owner_d   = OWNER_TAB;
          op_d      = OP_READ;
          addr_d    = tab_addr;
          tab_ack_d = 1'b1;
          if (host_req) burst_d = burst_q + 8'd1;
        end else if (host_req) begin
          state_d    = ST_ISSUE;
          owner_d    = OWNER_HOST;
          op_d       = host_op;
          addr_d     = host_addr;
          host_ack_d = 1'b1;
          burst_d    = '0;
        end
      end
      ST_ISSUE: begin
        wait_d   = '0;
        rd_cnt_d = '0;
`ifdef QSPI_ARB_TIMEOUT_EN
        wd_d     = '0;
`endif
        if (op_to_cmd(op_q) == 5'b0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cmd_d   = op_to_cmd(op_q);
          state_d = ST_WAIT_RISE;
        end
      end
      ST_WAIT_RISE: begin
        if (spi_flash_busy) begin
          state_d = ST_WAIT_FALL;
        end else if (wait_q == RISE_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_WAIT_FALL: begin
        if (spi_rd_valid && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        if (!spi_flash_busy) begin
          state_d = ST_DONE;
        end
`ifdef QSPI_ARB_TIMEOUT_EN
        else if (wd_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q + 24'd1;
        end
`endif
      end
      ST_DONE: begin
        host_done_d = (owner_q == OWNER_HOST);
        host_err_d  = (owner_q == OWNER_HOST) && err_q;
        tab_done_d  = (owner_q == OWNER_TAB);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_HOST;
      op_q        <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      burst_q     <= '0;
      wait_q      <= '0;
      rd_cnt_q    <= '0;
      cmd_q       <= '0;
      host_ack_q  <= 1'b0;
      tab_ack_q   <= 1'b0;
      host_done_q <= 1'b0;
      host_err_q  <= 1'b0;
      tab_done_q  <= 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      rd_cnt_q    <= rd_cnt_d;
      cmd_q       <= cmd_d;
      host_ack_q  <= host_ack_d;
      tab_ack_q   <= tab_ack_d;
      host_done_q <= host_done_d;
      host_err_q  <= host_err_d;
      tab_done_q  <= tab_done_d;
`ifdef QSPI_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  // The window only exists while a host page program is in flight.
  assign de_arm = (state_q == ST_WAIT_RISE || state_q == ST_WAIT_FALL) &&
                  owner_q == OWNER_HOST && op_q == OP_PROG;

  qspi_de_window #(.DE_LEN(DE_LEN)) u_de_window (
    .clk     (clk),
    .rst     (rst),
    .arm     (de_arm),
    .data_en (spi_data_en),
    .clear   (state_d == ST_DONE),
    .de      (spi_flash_de)
  );

  assign host_ack                   = host_ack_q;
  assign host_done                  = host_done_q;
  assign host_err                   = host_err_q;
  assign tab_ack                    = tab_ack_q;
  assign tab_done                   = tab_done_q;
  assign spi_read_puls              = cmd_q[CMD_READ];
  assign spi_chip_id_read_puls      = cmd_q[CMD_CHIP_ID];
  assign spi_enter_byte_4_addr_puls = cmd_q[CMD_EN4B];
  assign spi_page_prgm_4_byte_puls  = cmd_q[CMD_PROG];
  assign spi_erase_4_sector_puls    = cmd_q[CMD_SERASE];
  assign spi_address                = addr_q;
  assign owner                      = owner_q;
  assign arb_busy                   = (state_q != ST_IDLE);
  assign rd_byte_cnt                = rd_cnt_q;

endmodule

// File: doc/qspi_cmd_arbiter.md
Name: qspi_cmd_arbiter

Overview:
- Sequences the quad_spi flash engine and shares it between two requesters: the host command port (chip-ID, enter-4-byte, page program, sector erase, read) and the NOR-table loader (read only).
- Sits between the requesters and quad_spi, and owns all of quad_spi's command pulses, the 24-bit address and the program-data enable window.
- Only one operation is in flight at a time. Each grant produces exactly one command pulse and completes on the fall of flash_busy.

Parameters:
- DE_LEN, 514: number of cycles spi_flash_de stays high after spi_data_en during page program.
- BUSY_WAIT, 64: maximum cycles from the command pulse to the rise of spi_flash_busy.
- MAX_TAB_BURST, 4: number of consecutive table grants allowed while host_req is pending.
- TIMEOUT, 2^24-1: maximum cycles of busy, used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- host_req  in  1  level; held until host_ack
- host_op  in  8  opcode: 0x04 chip-ID, 0x08 enter-4-byte, 0x01 page program, 0x02 sector erase, 0x20 read
- host_addr  in  24  flash address
- host_ack  out  1  one-cycle pulse; request accepted and op/addr captured
- host_done  out  1  one-cycle pulse at completion
- host_err  out  1  one-cycle pulse, coincident with host_done, on error
- tab_req  in  1  level; held until tab_ack
- tab_addr  in  24  table read address
- tab_ack  out  1  one-cycle pulse
- tab_done  out  1  one-cycle pulse
- spi_read_puls, spi_chip_id_read_puls, spi_enter_byte_4_addr_puls, spi_page_prgm_4_byte_puls, spi_erase_4_sector_puls  out  1 each  command pulses to quad_spi
- spi_address  out  24  registered address; stable from ISSUE until DONE
- spi_flash_de  out  1  program-data window
- spi_data_en  in  1  from quad_spi
- spi_flash_busy  in  1  from quad_spi
- spi_rd_valid  in  1  read byte strobe
- owner  out  1  0 = host, 1 = table; valid while arb_busy
- arb_busy  out  1  high in every state except IDLE
- rd_byte_cnt  out  16  bytes received in the current read op

Behaviour:
- Reset (rst=0 at a clk edge): the FSM goes to IDLE. All outputs are 0. Counters clear.
- Reset mid-operation: aborts immediately. No done or err pulse is issued.
- States:
  - IDLE: grant a request, capture op/addr, pulse ack, go to ISSUE.
  - ISSUE: exactly one command pulse for one cycle, go to WAIT_RISE.
  - WAIT_RISE: wait for spi_flash_busy=1, then go to WAIT_FALL.
  - WAIT_FALL: wait for spi_flash_busy=0, then go to DONE.
  - DONE: pulse done (and err if applicable), go to IDLE.
- Latency: ack occurs in the cycle after req is sampled in IDLE. The command pulse follows ack by 1 cycle.
- Arbitration:
  - Table requests have priority.
  - A burst counter increments on each table grant made while host_req=1.
  - When the counter reaches MAX_TAB_BURST, the host wins the next grant and the counter clears.
  - Any host grant also clears the counter.
  - If both requests arrive in the same cycle and the counter is below limit, the table wins.
- A host opcode outside the list is acked and goes directly to DONE with host_err=1. No command pulse is issued.
- If WAIT_RISE exceeds BUSY_WAIT cycles: go to DONE with err=1.
  - err is reported as host_err when owner=0.
  - When owner=1, tab_done is pulsed only; the table port has no err output.
- Page program:
  - spi_flash_de rises the cycle after spi_data_en=1.
  - It stays high for exactly DE_LEN cycles, then drops.
  - It is forced low on DONE.
- rd_byte_cnt clears on ISSUE and increments on each spi_rd_valid while in WAIT_FALL. It saturates at 0xFFFF.
- A requester that drops req before ack simply loses the request. Requests arriving during arb_busy wait in IDLE.

Optional Feature:
- QSPI_ARB_TIMEOUT_EN defined: a busy watchdog counts cycles in WAIT_FALL.
  - On reaching TIMEOUT: go to DONE with err=1 and spi_flash_de forced low.
- QSPI_ARB_TIMEOUT_EN undefined: WAIT_FALL waits indefinitely and the TIMEOUT parameter is unused.

Decomposition:
- Package qspi_arb_pkg holds:
  - the opcode constants (OP_CHIP_ID=8'h04, OP_EN4B=8'h08, OP_PROG=8'h01, OP_SERASE=8'h02, OP_READ=8'h20)
  - the state enum
  - the owner encoding
- One natural sub-module: qspi_de_window, which implements the DE_LEN counter and spi_flash_de generation.

Test Plan:
- Table read at tab_addr=0x001000 → tab_ack, then one spi_read_puls with spi_address=0x001000. Model busy for 20 cycles with 4 rd_valid strobes → tab_done and rd_byte_cnt=4.
- host_req and tab_req asserted together, with tab_req continuously re-asserted → table granted 4 times, then the host granted on the 5th arbitration.
- host_op=0x01 and data_en pulse → spi_page_prgm_4_byte_puls, then spi_flash_de high for exactly 514 cycles, then host_done.
- host_op=0x55 → host_ack, then host_done with host_err=1 two cycles later and no command pulse.
- Busy never rises → host_err after 64 cycles in WAIT_RISE. With QSPI_ARB_TIMEOUT_EN and TIMEOUT=100, busy stuck high → err at cycle 100.
- rst=0 asserted during WAIT_FALL → all outputs 0 next edge and no done pulse. A subsequent request is served normally.
